// File: rtl/xy2_100_tx.sv
// xy2_100_tx - XY2-100 galvo link transmitter.
//
// Serialises 16-bit X/Y setpoints into continuous 20-bit XY2-100 frames
// (3'b001 control, 16 data bits MSB first, even parity) with a generated
// xy_clk. Every output is registered.
//
// Ports:
//   clk_ref      block clock (20 MHz)
//   sys_rstn     asynchronous active-low reset
//   enable       1 = send frames back-to-back, 0 = stop after current frame
//   sp_wr        one-cycle strobe, latches x_setpoint/y_setpoint into holding
//   x_setpoint   X position
//   y_setpoint   Y position
//   busy         1 while in LOAD or SHIFT
//   frame_start  pulse on the first cycle of bit 0
//   frame_done   pulse on the last cycle of bit 19
//   xy_clk       link clock, high for the first HALF_DIV cycles of each bit
//   xy_sync      link sync, low only during bit 19
//   xy_x, xy_y   link data
//   xy_status    link status return (optional feature only)
//   status_err   sticky status error (0 when the feature is compiled out)
//
// Optional feature: define XY2_STATUS_EN to synchronise xy_status and
// latch status_err when it reads 1 on a frame_done cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | lines low, divider held at 0, waiting for enable
// ST_LOAD  | one cycle: shadow <= holding, line levels held
// ST_SHIFT | bit bit_idx on the line for 2*HALF_DIV cycles

module xy2_100_tx #(
    parameter int          HALF_DIV = 5,
    parameter logic [15:0] SP_RESET = 16'h8000
) (
    input  logic        clk_ref,
    input  logic        sys_rstn,
    input  logic        enable,
    input  logic        sp_wr,
    input  logic [15:0] x_setpoint,
    input  logic [15:0] y_setpoint,
    output logic        busy,
    output logic        frame_start,
    output logic        frame_done,
    output logic        xy_clk,
    output logic        xy_sync,
    output logic        xy_x,
    output logic        xy_y,
    input  logic        xy_status,
    output logic        status_err
);

    localparam int             CW       = 9;
    localparam logic [CW-1:0]  CNT_HALF = CW'(HALF_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(2 * HALF_DIV - 1);
    localparam logic [4:0]     BIT_LAST = 5'd19;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [4:0]      bit_idx, bit_nxt;
    logic [15:0]     hold_x, hold_y, shad_x, shad_y;
    logic [15:0]     shad_x_nxt, shad_y_nxt;
    logic [19:0]     word_x, word_y;
    logic            busy_nxt, start_nxt, done_nxt;
    logic            clk_nxt, sync_nxt, x_nxt, y_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                bit_nxt = '0;
                if (enable) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_SHIFT;
                cnt_nxt   = '0;
                bit_nxt   = '0;
            end
            ST_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (bit_idx == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = enable ? ST_LOAD : ST_IDLE;
                    end else begin
                        bit_nxt = bit_idx + 5'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next-state values and registered, so
    // each output lines up with the state/counter it describes.
    always_comb begin
        shad_x_nxt = (state == ST_LOAD) ? hold_x : shad_x;
        shad_y_nxt = (state == ST_LOAD) ? hold_y : shad_y;
        // parity bit = XOR of bits 0..18 gives an even count of ones overall
        word_x = {3'b001, shad_x_nxt, ^{3'b001, shad_x_nxt}};
        word_y = {3'b001, shad_y_nxt, ^{3'b001, shad_y_nxt}};

        busy_nxt  = (state_nxt != ST_IDLE);
        start_nxt = (state_nxt == ST_SHIFT) && (bit_nxt == 5'd0) && (cnt_nxt == '0);
        done_nxt  = (state_nxt == ST_SHIFT) && (bit_nxt == BIT_LAST) && (cnt_nxt == CNT_LAST);
        clk_nxt   = 1'b0;
        sync_nxt  = 1'b0;
        x_nxt     = 1'b0;
        y_nxt     = 1'b0;
        case (state_nxt)
            ST_SHIFT: begin
                clk_nxt  = (cnt_nxt < CNT_HALF);
                sync_nxt = (bit_nxt != BIT_LAST);
                x_nxt    = word_x[BIT_LAST - bit_nxt];
                y_nxt    = word_y[BIT_LAST - bit_nxt];
            end
            ST_LOAD: begin
                // inter-frame cycle: clock low, data/sync keep their levels
                sync_nxt = xy_sync;
                x_nxt    = xy_x;
                y_nxt    = xy_y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            hold_x      <= SP_RESET;
            hold_y      <= SP_RESET;
            shad_x      <= SP_RESET;
            shad_y      <= SP_RESET;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            xy_clk      <= 1'b0;
            xy_sync     <= 1'b0;
            xy_x        <= 1'b0;
            xy_y        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_nxt;
            shad_x      <= shad_x_nxt;
            shad_y      <= shad_y_nxt;
            busy        <= busy_nxt;
            frame_start <= start_nxt;
            frame_done  <= done_nxt;
            xy_clk      <= clk_nxt;
            xy_sync     <= sync_nxt;
            xy_x        <= x_nxt;
            xy_y        <= y_nxt;
            if (sp_wr) begin
                hold_x <= x_setpoint;
                hold_y <= y_setpoint;
            end
        end
    end

`ifdef XY2_STATUS_EN
    logic [1:0] status_sync;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            status_sync <= '0;
            status_err  <= 1'b0;
        end else begin
            status_sync <= {status_sync[0], xy_status};
            if (frame_done && status_sync[1]) status_err <= 1'b1;
        end
    end
`else
    logic unused_status;
    assign unused_status = xy_status;
    assign status_err    = 1'b0;
`endif

endmodule
